// File: rtl/ucode_pkg.sv
// ucode_pkg: shared word layout, width helpers and state encoding for the microcode controller
// Word layout, LSB first:
//   two units of {v, sel1[NSEL], sel2[NSEL], op} (ALU, then multiplier),
//   reg_en[NREG], result, last.
package ucode_pkg;
    localparam int NSEL_DEF  = 4;
    localparam int NREG_DEF  = 16;
    localparam int DEPTH_DEF = 16;
    localparam int V_OFF     = 0;
    localparam int SEL1_OFF  = 1;
    function automatic int unit_w(input int nsel);
        return 2 * nsel + 2;
    endfunction
    function automatic int sel2_off(input int nsel);
        return SEL1_OFF + nsel;
    endfunction
    function automatic int op_off(input int nsel);
        return SEL1_OFF + 2 * nsel;
    endfunction
    function automatic int reg_off(input int nsel);
        return 2 * unit_w(nsel);
    endfunction
    function automatic int uw(input int nsel, input int nreg);
        return 2 * unit_w(nsel) + nreg + 2;
    endfunction
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/ucode_store.sv
// ucode_store: DEPTH x UW flop array, async clear, one gated write port, async read port
// Ports: clk, rst (async, active-high clears every word), we/waddr/wdata (write),
//        raddr/rdata (combinational read).
module ucode_store #(
    parameter int DEPTH = 16,
    parameter int UW    = 38,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [UW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [UW-1:0] rdata
);
    logic [UW-1:0] mem [DEPTH];
    always_ff @(posedge clk or posedge rst)
        if (rst) mem <= '{default: '0};
        else if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/ucode_controller.sv
// ucode_controller: microcode-driven schedule controller for the shared ALU/multiplier datapath
// Ports: clk, rst (async, active-high); start launches a run from IDLE;
//        ucode_we/ucode_addr/ucode_wdata load the store (IDLE only);
//        op_ready (idle), done_next (1-cycle end pulse), result_en, ALU and
//        multiplier selects/ops, reg_en, sched_err (sticky store overrun).
module ucode_controller
    import ucode_pkg::*;
#(
    parameter int NSEL  = NSEL_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int UW   = uw(NSEL, NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            ucode_we,
    input  logic [AW-1:0]   ucode_addr,
    input  logic [UW-1:0]   ucode_wdata,
    output logic            op_ready,
    output logic            done_next,
    output logic            result_en,
    output logic [NSEL-1:0] alu1_sel1,
    output logic [NSEL-1:0] alu1_sel2,
    output logic            alu1_op,
    output logic [NSEL-1:0] mul1_sel1,
    output logic [NSEL-1:0] mul1_sel2,
    output logic            mul1_op,
    output logic [NREG-1:0] reg_en,
    output logic            sched_err
);
    localparam int MUL  = unit_w(NSEL);
    localparam int REG  = reg_off(NSEL);
    localparam int RES  = REG + NREG;
    localparam int LAST = RES + 1;
    state_t        state, state_nxt;
    logic [AW-1:0] pc;
    logic [UW-1:0] word;
    logic          run, last, at_end, alu_v, mul_v;
    ucode_store #(.DEPTH(DEPTH), .UW(UW)) u_store (
        .clk   (clk),
        .rst   (rst),
        .we    (ucode_we && state == S_IDLE),
        .waddr (ucode_addr),
        .wdata (ucode_wdata),
        .raddr (pc),
        .rdata (word)
    );
    assign last   = word[LAST];
    assign at_end = pc == AW'(DEPTH - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state == S_IDLE ? (start ? S_RUN : S_IDLE)
                  : state == S_RUN  ? (last || at_end ? S_DONE : S_RUN)
                  : S_IDLE;
    end
    // The last store entry never wraps: without a last flag the run ends and flags the overrun.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pc        <= '0;
            sched_err <= 1'b0;
        end else if (state == S_IDLE && start) begin
            pc        <= '0;
            sched_err <= 1'b0;
        end else if (state == S_RUN && !last) begin
            if (at_end) sched_err <= 1'b1;
            else pc <= pc + 1'b1;
        end
    always_comb begin
        run       = state == S_RUN;
        alu_v     = run && word[V_OFF];
        mul_v     = run && word[MUL + V_OFF];
        op_ready  = state == S_IDLE;
        done_next = state == S_DONE;
        result_en = run && word[RES];
        reg_en    = run ? word[REG +: NREG] : '0;
        alu1_sel1 = alu_v ? word[SEL1_OFF +: NSEL] : '0;
        alu1_sel2 = alu_v ? word[sel2_off(NSEL) +: NSEL] : '0;
        alu1_op   = alu_v && word[op_off(NSEL)];
        mul1_sel1 = mul_v ? word[MUL + SEL1_OFF +: NSEL] : '0;
        mul1_sel2 = mul_v ? word[MUL + sel2_off(NSEL) +: NSEL] : '0;
        mul1_op   = mul_v && word[MUL + op_off(NSEL)];
    end
endmodule

// File: tb/tb_ucode_controller.sv
// tb_ucode_controller: directed self-checking bench for ucode_controller
module tb_ucode_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ucode_we = 1'b0;
    logic [3:0]  ucode_addr = '0;
    logic [37:0] ucode_wdata = '0;
    logic        op_ready, done_next, result_en, alu1_op, mul1_op, sched_err;
    logic [3:0]  alu1_sel1, alu1_sel2, mul1_sel1, mul1_sel2;
    logic [15:0] reg_en;
    logic [37:0] obs;
    logic [37:0] sexp [7];
    logic [37:0] neww, newexp, w2a, w2b, e2a, e2b;
    int errors = 0;
    int checks = 0;

    ucode_controller dut (
        .clk(clk), .rst(rst), .start(start),
        .ucode_we(ucode_we), .ucode_addr(ucode_addr), .ucode_wdata(ucode_wdata),
        .op_ready(op_ready), .done_next(done_next), .result_en(result_en),
        .alu1_sel1(alu1_sel1), .alu1_sel2(alu1_sel2), .alu1_op(alu1_op),
        .mul1_sel1(mul1_sel1), .mul1_sel2(mul1_sel2), .mul1_op(mul1_op),
        .reg_en(reg_en), .sched_err(sched_err)
    );

    always #5 clk = ~clk;

    assign obs = {op_ready, done_next, result_en, alu1_sel1, alu1_sel2, alu1_op,
                  mul1_sel1, mul1_sel2, mul1_op, reg_en, sched_err};

    function automatic logic [37:0] wd(input logic av, input logic [3:0] as1, as2, input logic aop,
                                       input logic mv, input logic [3:0] ms1, ms2, input logic mop,
                                       input logic [15:0] rg, input logic res, lst);
        return {lst, res, rg, mop, ms2, ms1, mv, aop, as2, as1, av};
    endfunction

    function automatic logic [37:0] ex(input logic rdy, dn, ren, input logic [3:0] as1, as2,
                                       input logic aop, input logic [3:0] ms1, ms2, input logic mop,
                                       input logic [15:0] rg, input logic err);
        return {rdy, dn, ren, as1, as2, aop, ms1, ms2, mop, rg, err};
    endfunction

    function automatic logic [37:0] idle_e(input logic err);
        return ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, err);
    endfunction

    function automatic logic [37:0] done_e(input logic err);
        return ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0, err);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [37:0] got, input logic [37:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic write(input logic [3:0] a, input logic [37:0] d);
        ucode_we = 1'b1;
        ucode_addr = a;
        ucode_wdata = d;
        step;
        ucode_we = 1'b0;
    endtask

    // Entered in RUN cycle 1 of the 7-word schedule; leaves in the following IDLE cycle.
    task automatic run7(input string tag, input logic [37:0] first);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("%s_c%0d", tag, i + 1), obs, i == 0 ? first : sexp[i]);
            step;
        end
        check({tag, "_done"}, obs, done_e(0));
        step;
        check({tag, "_idle"}, obs, idle_e(0));
    endtask

    initial begin
        logic [3:0] m1 [6];
        logic [3:0] m2 [6];
        int         rr [6];
        logic [37:0] sw [7];
        m1 = '{4'd0, 4'd8, 4'd9, 4'd4, 4'd11, 4'd12};
        m2 = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7};
        rr = '{2, 4, 6, 9, 11, 13};
        for (int i = 0; i < 6; i++) begin
            sw[i]   = wd(0, i == 0 ? 4'hF : 4'h0, 4'h0, i == 0, 1, m1[i], m2[i], 1, 16'h1 << rr[i], 0, 0);
            sexp[i] = ex(0, 0, 0, 0, 0, 0, m1[i], m2[i], 1, 16'h1 << rr[i], 0);
        end
        sw[6]   = wd(1, 4'd10, 4'd13, 0, 0, 4'd3, 4'd7, 1, 16'h4000, 1, 1);
        sexp[6] = ex(0, 0, 1, 4'd10, 4'd13, 0, 0, 0, 0, 16'h4000, 0);
        neww    = wd(1, 4'd3, 4'd5, 1, 0, 0, 0, 0, 16'h0002, 0, 0);
        newexp  = ex(0, 0, 0, 4'd3, 4'd5, 1, 0, 0, 0, 16'h0002, 0);
        w2a     = wd(0, 0, 0, 0, 1, 4'd1, 4'd2, 1, 16'h0008, 0, 0);
        e2a     = ex(0, 0, 0, 0, 0, 0, 4'd1, 4'd2, 1, 16'h0008, 0);
        w2b     = wd(1, 4'd4, 4'd5, 0, 0, 0, 0, 0, 16'h0020, 1, 1);
        e2b     = ex(0, 0, 1, 4'd4, 4'd5, 0, 0, 0, 0, 16'h0020, 0);

        step;
        check("reset_held", obs, idle_e(0));
        rst = 1'b0;
        step;
        check("reset_idle", obs, idle_e(0));

        for (int i = 0; i < 7; i++) write(4'(i), sw[i]);
        check("loaded_idle", obs, idle_e(0));
        start = 1'b1;
        step;
        start = 1'b0;
        run7("sched", sexp[0]);

        start = 1'b1;
        step;
        start = 1'b0;
        ucode_we = 1'b1;
        ucode_addr = 4'd0;
        ucode_wdata = neww;
        run7("wr_in_run", sexp[0]);
        ucode_we = 1'b0;
        start = 1'b1;
        step;
        start = 1'b0;
        run7("rerun", sexp[0]);

        ucode_we = 1'b1;
        ucode_addr = 4'd0;
        ucode_wdata = neww;
        start = 1'b1;
        step;
        ucode_we = 1'b0;
        start = 1'b0;
        run7("wr_start", newexp);

        start = 1'b1;
        step;
        start = 1'b0;
        check("rst_run_c1", obs, newexp);
        step;
        check("rst_run_c2", obs, sexp[1]);
        step;
        check("rst_run_c3", obs, sexp[2]);
        rst = 1'b1;
        #1;
        check("rst_async", obs, idle_e(0));
        step;
        check("rst_hold", obs, idle_e(0));
        rst = 1'b0;
        step;

        start = 1'b1;
        step;
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("empty_c%0d", i + 1), obs, '0);
            step;
        end
        check("empty_done", obs, done_e(1));
        step;
        check("empty_idle", obs, idle_e(1));

        write(4'd0, w2a);
        write(4'd1, w2b);
        check("err_sticky", obs, idle_e(1));
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step;
            case ((c - 1) % 4)
                0:       check($sformatf("b2b_c%0d", c), obs, e2a);
                1:       check($sformatf("b2b_c%0d", c), obs, e2b);
                2:       check($sformatf("b2b_c%0d", c), obs, done_e(0));
                default: check($sformatf("b2b_c%0d", c), obs, idle_e(0));
            endcase
        end
        start = 1'b0;
        step;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ucode_controller.md
# ucode_controller

Table-driven replacement for the generated per-schedule FSM controllers. It drives the shared-ALU / shared-multiplier datapath from a loadable microcode store instead of hard-coded states. Each microcode word is one schedule cycle: operand selects, op bits, register enables, result strobe and an end-of-schedule flag. The block keeps the existing `start` / `op_ready` / `done_next` / `result_en` handshake, so it drops into place of a generated controller without datapath changes.

## Interface
- `NSEL`, 4: width of each operand select.
- `NREG`, 16: number of datapath register enables.
- `DEPTH`, 16: microcode entries; `AW = $clog2(DEPTH)`.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request a schedule run.
- `ucode_we` in 1: microcode write strobe.
- `ucode_addr` in AW: write address.
- `ucode_wdata` in `UW = 2*(2*NSEL+2)+NREG+2`: word to store.
- `op_ready` out 1: idle, start accepted.
- `done_next` out 1: schedule finished (1-cycle pulse).
- `result_en` out 1: load result register.
- `alu1_sel1`, `alu1_sel2` out NSEL: ALU operand selects.
- `alu1_op` out 1: ALU op.
- `mul1_sel1`, `mul1_sel2` out NSEL: multiplier operand selects.
- `mul1_op` out 1: multiplier op.
- `reg_en` out NREG: per-register load enables.
- `sched_err` out 1: sticky; the last schedule overran the store.

## Operation
- Word fields, LSB first:
  - `alu_v`, `alu_sel1`, `alu_sel2`, `alu_op`
  - `mul_v`, `mul_sel1`, `mul_sel2`, `mul_op`
  - `reg_en[NREG]`, `result`, `last`
- FSM states are IDLE, RUN and DONE.
- IDLE: `op_ready=1`.
  - If `start`: `pc<=0`, `sched_err<=0`, go to RUN.
- RUN: outputs are decoded combinationally from `ucode[pc]`.
  - If `last`, or `pc==DEPTH-1`: go to DONE.
  - Otherwise `pc<=pc+1`.
  - If `pc==DEPTH-1` and `last==0`: also set `sched_err<=1` (overrun guard; no wrap to 0).
- DONE: `done_next=1`, go to IDLE.
- Output defaults:
  - Every output not driven by the current state or word is 0.
  - If `alu_v==0`, `alu1_sel1/2` and `alu1_op` are 0.
  - If `mul_v==0`, `mul1_sel1/2` and `mul1_op` are 0.
  - `reg_en` and `result_en` are 0 outside RUN.
- Microcode writes:
  - Accepted only in IDLE. `ucode_we` in RUN or DONE is ignored; the store is unchanged.
  - A write in the same IDLE cycle as `start` is committed. The first RUN cycle sees the new data.
- `start` in RUN or DONE is ignored and not queued.
- Reset (any time, including mid-run):
  - state=IDLE, pc=0, `sched_err=0`, all microcode words cleared to 0.
  - In-flight outputs drop to 0 asynchronously.
  - `op_ready` reads 1 while `rst` is high.

## Timing
- `start` is sampled at edge E0. The word at pc=0 drives outputs in the cycle after E0.
- An N-word schedule (`last` in word N-1) occupies N RUN cycles.
- `done_next` is high in cycle N+1 after E0, and `op_ready` in cycle N+2.
- Back-to-back runs: a `start` held high re-launches at the first IDLE edge. Period is N+2 cycles.
- All control outputs are combinational from state, pc and the store. They are valid the whole cycle for the datapath's edge.
- Store is a flop array with one write port. Read is asynchronous.

## Structure
- Shared package `ucode_pkg` holds:
  - Field offset/width localparams for the word layout, all derived from NSEL and NREG.
  - The `UW` formula.
  - State encoding enum (IDLE, RUN, DONE).
- Sub-module `ucode_store`: DEPTH×UW flop array with async reset clear, a gated write port and an async read port.
- FSM, pc and field decode stay in `ucode_controller`.

## Test plan
- Load the 7-word schedule: mul 0×1→reg2, 8×2→reg4, 9×3→reg6, 4×5→reg9, 11×6→reg11, 12×7→reg13, then alu 10+13→reg14 with `result=1`, `last=1`.
  - Pulse `start`.
  - Per-cycle selects and enables match that order exactly.
  - `result_en` is high only in cycle 7; `done_next` in cycle 8; `op_ready` in cycle 9.
- Run after reset with no load:
  - 16 RUN cycles with all outputs 0, then `done_next`.
  - `sched_err=1`; it clears on the next accepted `start`.
- Issue `ucode_we` to addr 0 during RUN:
  - The current run is unaffected.
  - A rerun shows the original word 0.
- Write word 0 and assert `start` in the same IDLE cycle: the first RUN cycle shows the new word 0.
- Assert `rst` in RUN cycle 3:
  - Outputs go to 0 immediately; `op_ready=1`.
  - The store is cleared (a rerun behaves as unloaded).
- Hold `start` high with a 2-word schedule: `done_next` pulses every 4 cycles.
